// File: rtl/fc_layer_ctrl_if.sv
// Bundle of fc_layer_ctrl control, RAM, datapath and result-stream signals.
// master = controller side, slave = environment (RAMs, MAC, result sink).
interface fc_layer_ctrl_if;
  logic        go;
  logic [9:0]  in_len;
  logic [9:0]  out_len;
  logic        busy;
  logic        done;
  logic        err;
  logic        act_rd;
  logic [9:0]  act_addr;
  logic [7:0]  act_data;
  logic        w_rd;
  logic [19:0] w_addr;
  logic [23:0] w_data;
  logic        start;
  logic [7:0]  vec1;
  logic [23:0] vec2;
  logic        o_valid;
  logic [56:0] o;
  logic        res_valid;
  logic [9:0]  res_idx;
  logic [56:0] res_data;
  logic        res_ready;

  modport master (
    input  go, in_len, out_len, act_data, w_data, o_valid, o, res_ready,
    output busy, done, err, act_rd, act_addr, w_rd, w_addr,
           start, vec1, vec2, res_valid, res_idx, res_data
  );

  modport slave (
    output go, in_len, out_len, act_data, w_data, o_valid, o, res_ready,
    input  busy, done, err, act_rd, act_addr, w_rd, w_addr,
           start, vec1, vec2, res_valid, res_idx, res_data
  );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer: streams activation/weight pairs to a MAC per neuron
// and returns one result per neuron. Optional WAIT watchdog: FC_CTRL_WATCHDOG_EN.
module fc_layer_ctrl (
  input  logic           clk,
  input  logic           reset,
  fc_layer_ctrl_if.master bus
);
  localparam int STAGES = 1;

  typedef enum logic [2:0] {IDLE, FEED, WAIT, OUT, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]        len_in, len_out, n, i;
  logic [19:0]       wptr;
  logic [STAGES:0]   vld_pipe;
  logic [7:0]        vec1_q;
  logic [23:0]       vec2_q;
  logic [56:0]       res_q;
  logic              go_ok, go_nil, feed_last, hs, more, wd_trip;

  assign go_ok     = (state == IDLE) && bus.go && (bus.in_len != '0) && (bus.out_len != '0);
  assign go_nil    = (state == IDLE) && bus.go && !((bus.in_len != '0) && (bus.out_len != '0));
  assign feed_last = (state == FEED) && (i == len_in - 10'd1);
  assign hs        = (state == OUT) && bus.res_ready;
  assign more      = n < (len_out - 10'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go_ok) state_nxt = FEED;
            else if (go_nil) state_nxt = DONE;
      FEED: if (feed_last) state_nxt = WAIT;
      WAIT: if (bus.o_valid) state_nxt = OUT;
            else if (wd_trip) state_nxt = DONE;
      OUT:  if (hs) state_nxt = more ? FEED : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight pointer runs across neurons; only an accepted go rewinds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_in  <= '0;
      len_out <= '0;
      n       <= '0;
      i       <= '0;
      wptr    <= '0;
      res_q   <= '0;
    end else begin
      if (go_ok) begin
        len_in  <= bus.in_len;
        len_out <= bus.out_len;
        n       <= '0;
        i       <= '0;
        wptr    <= '0;
      end
      if (state == FEED) begin
        wptr <= wptr + 20'd1;
        i    <= feed_last ? 10'd0 : i + 10'd1;
      end
      if (hs && more) n <= n + 10'd1;
      if ((state == WAIT) && bus.o_valid) res_q <= bus.o;
    end
  end

  // Stage 0: RAM data returning; stage 1: registered operands presented with start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      vec1_q   <= '0;
      vec2_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == FEED};
      vec1_q   <= vld_pipe[0] ? bus.act_data : 8'd0;
      vec2_q   <= vld_pipe[0] ? bus.w_data   : 24'd0;
    end
  end

`ifdef FC_CTRL_WATCHDOG_EN
  logic [9:0] wd_cnt;
  logic       err_q;

  assign wd_trip = (state == WAIT) && !bus.o_valid && (wd_cnt == 10'h3FF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= ((state == WAIT) && !bus.o_valid) ? wd_cnt + 10'd1 : 10'd0;
      if (go_ok)        err_q <= 1'b0;
      else if (wd_trip) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_trip = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.act_rd    = (state == FEED);
  assign bus.w_rd      = (state == FEED);
  assign bus.act_addr  = i;
  assign bus.w_addr    = wptr;
  assign bus.start     = vld_pipe[STAGES];
  assign bus.vec1      = vec1_q;
  assign bus.vec2      = vec2_q;
  assign bus.res_valid = (state == OUT);
  assign bus.res_idx   = n;
  assign bus.res_data  = res_q;
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Scoreboard bench for fc_layer_ctrl: RAM and MAC models, expected per-neuron sums queued at go.
module tb_fc_layer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  fc_layer_ctrl_if bus();

  fc_layer_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [9:0] idx; logic [56:0] data; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_chk = 0, n_err = 0;
  int done_cnt = 0, rd_cnt = 0, start_cnt = 0, cyc = 0, last_rd_cyc = 0, done_cyc = 0;
  int cur_in = 1, exp_i = 0, exp_w = 0;
  int dp_dly = 4, dp_fires = 0, scnt = 0, cd = 0;
  logic [56:0] acc = '0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] act_f(int a);
    return 8'(a * 13 + 7);
  endfunction

  function automatic logic [23:0] w_f(int a);
    return 24'(a * 40503 + 11);
  endfunction

  function automatic logic [56:0] exp_sum(int nn, int nin);
    logic [56:0] s = '0;
    for (int k = 0; k < nin; k++) s += 57'(act_f(k)) * 57'(w_f(nn * nin + k));
    return s;
  endfunction

  // RAMs: one-cycle read latency
  always @(posedge clk) begin
    if (bus.act_rd) bus.act_data <= act_f(int'(bus.act_addr));
    if (bus.w_rd)   bus.w_data   <= w_f(int'(bus.w_addr));
  end

  always @(posedge clk) cyc++;

  // MAC model: accumulates cur_in operand pairs, answers dp_dly cycles after the last one
  always @(negedge clk) begin
    if (reset) begin
      bus.o_valid = 1'b0;
      bus.o = '0;
      acc = '0; scnt = 0; cd = 0;
    end else begin
      if (bus.o_valid) bus.o_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.o_valid = 1'b1;
      end
      if (!bus.start) begin
        chk("vec1_idle", bus.vec1, 0);
        chk("vec2_idle", bus.vec2, 0);
      end else begin
        start_cnt++;
        acc += 57'(bus.vec1) * 57'(bus.vec2);
        scnt++;
        if (scnt == cur_in) begin
          scnt = 0;
          if (dp_fires > 0) begin
            dp_fires--;
            bus.o = acc;
            if (dp_dly == 0) bus.o_valid = 1'b1;
            else cd = dp_dly;
          end
          acc = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.act_rd) begin
      chk("act_addr", bus.act_addr, exp_i);
      chk("w_addr", bus.w_addr, exp_w);
      chk("w_rd", bus.w_rd, 1);
      exp_w++;
      exp_i = (exp_i == cur_in - 1) ? 0 : exp_i + 1;
      rd_cnt++;
      last_rd_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!reset && bus.res_valid && bus.res_ready) begin
      chk("res_q", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_idx", bus.res_idx, e.idx);
        chk("res_data", bus.res_data, e.data);
      end
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic start_layer(int nin, int nout);
    cur_in = nin; exp_i = 0; exp_w = 0;
    if (nin != 0 && nout != 0)
      for (int k = 0; k < nout; k++) sb.push_back('{idx: 10'(k), data: exp_sum(k, nin)});
    @(posedge clk); #1;
    bus.go = 1'b1; bus.in_len = 10'(nin); bus.out_len = 10'(nout);
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done_cnt > d0, 1);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_act_rd"}, bus.act_rd, 0);
    chk({tag, "_w_rd"}, bus.w_rd, 0);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_act_addr"}, bus.act_addr, 0);
    chk({tag, "_w_addr"}, bus.w_addr, 0);
    chk({tag, "_vec"}, {bus.vec1, bus.vec2}, 0);
    chk({tag, "_res_idx"}, bus.res_idx, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
  endtask

  initial begin
    int r0, d0, s0, k;
    bus.go = 1'b0; bus.in_len = '0; bus.out_len = '0; bus.res_ready = 1'b1;
    #1 reset = 1'b1;
    #12 chk_idle("rst");
    @(posedge clk); #1 reset = 1'b0;

    // two neurons of three, MAC answers 4 cycles after last start
    dp_dly = 4; dp_fires = 2; r0 = rd_cnt; d0 = done_cnt;
    start_layer(3, 2);
    wait_done("t1_done", 200);
    tick(3);
    chk("t1_reads", rd_cnt - r0, 6);
    chk("t1_ndone", done_cnt - d0, 1);
    chk("t1_sb", sb.size(), 0);
    chk("t1_busy", bus.busy, 0);

    // result held under backpressure
    bus.res_ready = 1'b0; dp_fires = 1; d0 = done_cnt;
    start_layer(4, 1);
    k = 0;
    while (!bus.res_valid && k < 100) begin @(negedge clk); k++; end
    chk("t2_rv", bus.res_valid, 1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t2_hold_v", bus.res_valid, 1);
      if (sb.size() > 0) chk("t2_hold_d", bus.res_data, sb[0].data);
    end
    chk("t2_nodone", done_cnt - d0, 0);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    wait_done("t2_done", 20);
    chk("t2_sb", sb.size(), 0);

    // zero-length layer
    r0 = rd_cnt; s0 = start_cnt; d0 = done_cnt;
    start_layer(0, 5);
    chk("t3_done", bus.done, 1);
    tick(5);
    chk("t3_reads", rd_cnt - r0, 0);
    chk("t3_starts", start_cnt - s0, 0);
    chk("t3_ndone", done_cnt - d0, 1);
    chk("t3_busy", bus.busy, 0);

    // go during FEED is ignored
    dp_dly = 2; dp_fires = 2; r0 = rd_cnt;
    start_layer(5, 2);
    tick(2);
    bus.go = 1'b1; bus.in_len = 10'd7; bus.out_len = 10'd3;
    tick(1);
    bus.go = 1'b0;
    wait_done("t4_done", 200);
    chk("t4_reads", rd_cnt - r0, 10);
    chk("t4_sb", sb.size(), 0);

    // result arrives while start is still high
    dp_dly = 0; dp_fires = 3; s0 = start_cnt;
    start_layer(2, 3);
    wait_done("t5_done", 200);
    chk("t5_starts", start_cnt - s0, 6);
    chk("t5_sb", sb.size(), 0);

    // reset during WAIT of neuron 1, then clean restart
    dp_dly = 3; dp_fires = 1; r0 = rd_cnt;
    start_layer(3, 2);
    k = 0;
    while (rd_cnt - r0 < 6 && k < 200) begin @(negedge clk); k++; end
    chk("t6_reads", rd_cnt - r0, 6);
    tick(2);
    chk("t6_idx", bus.res_idx, 1);
    chk("t6_busy", bus.busy, 1);
    #3 reset = 1'b1;
    #1 chk_idle("t6");
    sb.delete();
    tick(2);
    reset = 1'b0;
    dp_dly = 1; dp_fires = 2; r0 = rd_cnt;
    start_layer(3, 2);
    wait_done("t6_redo", 200);
    chk("t6_rereads", rd_cnt - r0, 6);
    chk("t6_sb", sb.size(), 0);

    // MAC never answers
    dp_fires = 0; d0 = done_cnt;
    start_layer(2, 1);
`ifdef FC_CTRL_WATCHDOG_EN
    wait_done("t7_wd_done", 1200);
    chk("t7_err", bus.err, 1);
    chk("t7_lat", done_cyc - last_rd_cyc, 1025);
    tick(2);
    chk("t7_sticky", bus.err, 1);
    sb.delete();
    dp_fires = 1; dp_dly = 2;
    start_layer(1, 1);
    chk("t7_errclr", bus.err, 0);
    wait_done("t7_after", 100);
`else
    tick(1100);
    chk("t7_busy", bus.busy, 1);
    chk("t7_nodone", done_cnt - d0, 0);
    chk("t7_err", bus.err, 0);
    reset = 1'b1;
    sb.delete();
    tick(2);
    reset = 1'b0;
    chk("t7_idle", bus.busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic rising-edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: go  in  1  start-layer pulse; in_len  in  10  elements per neuron; out_len  in  10  neurons per layer.
REQ-003 SHALL have ports: busy  out  1  layer in progress; done  out  1  one-cycle completion pulse; err  out  1  watchdog abort flag.
REQ-004 SHALL have ports: act_rd  out  1; act_addr  out  10; act_data  in  8  activation RAM, read data valid one cycle after act_rd.
REQ-005 SHALL have ports: w_rd  out  1; w_addr  out  20; w_data  in  24  weight RAM, read data valid one cycle after w_rd.
REQ-006 SHALL have ports: start  out  1; vec1  out  8; vec2  out  24  datapath operand strobe and operands.
REQ-007 SHALL have ports: o_valid  in  1; o  in  57  datapath result pulse and value.
REQ-008 SHALL have ports: res_valid  out  1; res_idx  out  10; res_data  out  57; res_ready  in  1  result stream, valid/ready.

Function
REQ-009 SHALL implement states IDLE, FEED, WAIT, OUT, DONE.
REQ-010 IDLE: go=1 with in_len!=0 and out_len!=0 SHALL latch both lengths, clear neuron index n and weight pointer, clear err, go to FEED.
REQ-011 IDLE: go=1 with either length 0 SHALL pulse done the next cycle, with no RAM read and no start.
REQ-012 go SHALL be ignored in every state except IDLE.
REQ-013 FEED: SHALL assert act_rd and w_rd for exactly in_len consecutive cycles, act_addr=0..in_len-1, w_addr=n*in_len+i (running pointer, never reset between neurons).
REQ-014 Read data SHALL be registered: a read issued at cycle t SHALL drive vec1=act_data, vec2=w_data, start=1 at cycle t+2.
REQ-015 start SHALL be high for exactly in_len contiguous cycles per neuron; vec1/vec2 SHALL be 0 when start=0.
REQ-016 After the last read, FEED SHALL go to WAIT; WAIT SHALL capture o into res_data on o_valid=1 and go to OUT.
REQ-017 o_valid arriving while start is still high SHALL be captured identically.
REQ-018 OUT: res_valid=1, res_idx=n; res_data/res_idx SHALL stay stable until res_valid&&res_ready.
REQ-019 On handshake: n<out_len-1 SHALL increment n and go to FEED; otherwise go to DONE.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 busy SHALL be 1 in FEED, WAIT, OUT, DONE, and 0 in IDLE.
REQ-022 o_valid outside WAIT SHALL be ignored.

Reset
REQ-023 Asserting reset SHALL, asynchronously and in any state, force IDLE and clear all outputs to 0: busy, done, err, act_rd, w_rd, start, res_valid, and all address, data and index buses.
REQ-024 After release from reset mid-layer, the block SHALL wait for a new go; it SHALL NOT resume.

Configuration
REQ-025 Macro FC_CTRL_WATCHDOG_EN defined: a 10-bit counter SHALL run in WAIT; 1024 cycles without o_valid SHALL set err=1 (sticky until next accepted go) and go to DONE, pulsing done.
REQ-026 FC_CTRL_WATCHDOG_EN undefined: there SHALL be no counter, WAIT SHALL wait indefinitely, and err SHALL be tied to 0.

Verification
REQ-027 in_len=3, out_len=2, o_valid 4 cycles after last start, res_ready=1: reads w_addr 0..5; two results, idx 0 then 1; one done pulse.
REQ-028 in_len=4, out_len=1, res_ready=0 for 10 cycles: res_valid and res_data held stable 10 cycles; done only after res_ready=1.
REQ-029 go with in_len=0, out_len=5: done the next cycle; act_rd, w_rd, start never asserted.
REQ-030 go pulsed again mid-FEED: no effect, addresses continue unbroken.
REQ-031 reset asserted in WAIT of neuron 1: all outputs 0 immediately; post-release go restarts at n=0, w_addr=0.
REQ-032 FC_CTRL_WATCHDOG_EN defined, o_valid never asserted: err=1 and done pulse 1024 cycles after WAIT entry; undefined: busy held.
